// File: rtl/clock_ratio_checker.sv
// Confirms a 1:2:4 period ratio between three divided clocks sampled in clk.
// Reports lock after consecutive passing checks, plus error pulse and sticky flag.
module clock_ratio_checker #(
    parameter int CNT_W      = 8,
    parameter int LOCK_COUNT = 4
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             main_in,
    input  logic             two_in,
    input  logic             four_in,
    input  logic             clr_err,
    output logic             locked,
    output logic             err_pulse,
    output logic             err_sticky,
    output logic [CNT_W-1:0] main_period,
    output logic [CNT_W-1:0] four_period
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] CHECK  = 2'd1;
    localparam logic [1:0] LOCKED = 2'd2;

    localparam logic [CNT_W-1:0] SAT    = '1;
    localparam logic [3:0]       LOCK_N = 4'(LOCK_COUNT);

    logic [2:0] s1, s2, s3;
    logic [2:0] rise;
    logic [2:0] seen;
    logic [2:0] pval;

    logic [2:0][CNT_W-1:0] cnt;
    logic [2:0][CNT_W-1:0] per;

    logic [1:0] state, state_n;
    logic [3:0] good_cnt, good_n;
    logic       err_n;

    logic [CNT_W+1:0] m_x, t_x, f_x;
    logic             bad_val;
    logic             pass;
    logic             chk;
    logic             stall;

    assign rise = s2 & ~s3;

    // Bit 0 = main, bit 1 = divide-by-2, bit 2 = divide-by-4.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            s1   <= '0;
            s2   <= '0;
            s3   <= '0;
            seen <= '0;
            pval <= '0;
            cnt  <= '0;
            per  <= '0;
        end else begin
            s1 <= {four_in, two_in, main_in};
            s2 <= s1;
            s3 <= s2;
            for (int i = 0; i < 3; i++) begin
                if (rise[i]) begin
                    cnt[i]  <= CNT_W'(1);
                    per[i]  <= cnt[i];
                    seen[i] <= 1'b1;
                    if (seen[i]) begin
                        pval[i] <= 1'b1;
                    end
                end else if (cnt[i] != SAT) begin
                    cnt[i] <= cnt[i] + CNT_W'(1);
                end
            end
        end
    end

    // The four period under test is the value being captured this cycle.
    always_comb begin
        m_x     = {2'b00, per[0]};
        t_x     = {2'b00, per[1]};
        f_x     = {2'b00, cnt[2]};
        bad_val = (per[0] == SAT) || (per[0] == '0)
               || (per[1] == SAT) || (per[1] == '0)
               || (cnt[2] == SAT) || (cnt[2] == '0);
        pass    = (t_x == (m_x << 1)) && (f_x == (m_x << 2)) && !bad_val;
        chk     = rise[2] && (&pval);
        stall   = (state == LOCKED) && (cnt[2] == SAT) && !rise[2];
    end

    always_comb begin
        state_n = state;
        good_n  = good_cnt;
        err_n   = 1'b0;
        unique case (state)
            IDLE: begin
                if (&pval) begin
                    state_n = CHECK;
                end
            end
            CHECK: begin
                if (chk) begin
                    if (pass) begin
                        good_n = good_cnt + 4'd1;
                        if (good_n == LOCK_N) begin
                            state_n = LOCKED;
                        end
                    end else begin
                        good_n = 4'd0;
                        err_n  = 1'b1;
                    end
                end
            end
            LOCKED: begin
                if ((chk && !pass) || stall) begin
                    state_n = CHECK;
                    good_n  = 4'd0;
                    err_n   = 1'b1;
                end
            end
            default: begin
                state_n = IDLE;
                good_n  = 4'd0;
            end
        endcase
    end

    // A new error or a pulse in flight beats a simultaneous clear.
    always_ff @(posedge clk or negedge resetn) begin
        if (!resetn) begin
            state      <= IDLE;
            good_cnt   <= 4'd0;
            err_pulse  <= 1'b0;
            err_sticky <= 1'b0;
        end else begin
            state      <= state_n;
            good_cnt   <= good_n;
            err_pulse  <= err_n;
            err_sticky <= err_n | err_pulse | (err_sticky & ~clr_err);
        end
    end

    assign locked      = (state == LOCKED);
    assign main_period = per[0];
    assign four_period = per[2];

endmodule

// File: tb/tb_clock_ratio_checker.sv
// Bench for clock_ratio_checker: table segments, corner sequences, random
// segments, all against an event-level reference model (CNT_W 8 and 4).
module tb_clock_ratio_checker;

    logic clk = 1'b0;
    logic resetn = 1'b0;
    logic main_in = 1'b0;
    logic two_in = 1'b0;
    logic four_in = 1'b0;
    logic clr_err = 1'b0;

    logic       lk8, ep8, es8;
    logic [7:0] mp8, fp8;
    logic       lk4, ep4, es4;
    logic [3:0] mp4, fp4;

    always #5 clk = ~clk;

    clock_ratio_checker #(.CNT_W(8), .LOCK_COUNT(4)) dut8 (
        .clk(clk), .resetn(resetn), .main_in(main_in), .two_in(two_in),
        .four_in(four_in), .clr_err(clr_err), .locked(lk8),
        .err_pulse(ep8), .err_sticky(es8), .main_period(mp8),
        .four_period(fp8)
    );

    clock_ratio_checker #(.CNT_W(4), .LOCK_COUNT(4)) dut4 (
        .clk(clk), .resetn(resetn), .main_in(main_in), .two_in(two_in),
        .four_in(four_in), .clr_err(clr_err), .locked(lk4),
        .err_pulse(ep4), .err_sticky(es4), .main_period(mp4),
        .four_period(fp4)
    );

    int nvec = 0;
    int nbad = 0;

    // Waveform generator: full periods in clk cycles, high for p/2 cycles.
    int pm = 2, p2 = 4, p4 = 8;
    int ph = 0;
    bit freeze4 = 1'b0;

    // Reference model, index 0 = CNT_W 8, index 1 = CNT_W 4.
    int sat[2] = '{255, 15};
    int lock_need = 4;
    int tnow;
    bit smp[3][4];
    int m_st[2];
    int m_good[2];
    bit m_pulse[2];
    bit m_sticky[2];
    int m_per[2][3];
    int m_last[2][3];
    int m_nr[2][3];

    function automatic void model_reset();
        tnow = 0;
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0;
            m_good[i] = 0;
            m_pulse[i] = 1'b0;
            m_sticky[i] = 1'b0;
            for (int x = 0; x < 3; x++) begin
                m_per[i][x] = 0;
                m_last[i][x] = 1;
                m_nr[i][x] = 0;
            end
        end
        for (int x = 0; x < 3; x++)
            for (int k = 0; k < 4; k++)
                smp[x][k] = 1'b0;
    endfunction

    // One clk edge: an input edge sampled at edge k is seen at edge k+2.
    function automatic void model_step(input bit a, input bit b,
                                       input bit c, input bit clr);
        bit nv[3];
        bit ev[3];
        int cb[3];
        int d, mp, tp, fq;
        bit allpv, pass, chk, err;
        nv[0] = a;
        nv[1] = b;
        nv[2] = c;
        tnow++;
        for (int x = 0; x < 3; x++) begin
            smp[x][3] = smp[x][2];
            smp[x][2] = smp[x][1];
            smp[x][1] = smp[x][0];
            smp[x][0] = nv[x];
            ev[x] = smp[x][2] && !smp[x][3];
        end
        for (int i = 0; i < 2; i++) begin
            for (int x = 0; x < 3; x++) begin
                d = tnow - m_last[i][x];
                cb[x] = (d > sat[i]) ? sat[i] : d;
            end
            allpv = (m_nr[i][0] >= 2) && (m_nr[i][1] >= 2)
                 && (m_nr[i][2] >= 2);
            mp = m_per[i][0];
            tp = m_per[i][1];
            fq = cb[2];
            pass = (tp == 2 * mp) && (fq == 4 * mp)
                && mp != 0 && tp != 0 && fq != 0
                && mp != sat[i] && tp != sat[i] && fq != sat[i];
            chk = ev[2] && allpv;
            err = 1'b0;
            case (m_st[i])
                0: if (allpv) m_st[i] = 1;
                1: if (chk) begin
                    if (pass) begin
                        m_good[i]++;
                        if (m_good[i] == lock_need) m_st[i] = 2;
                    end else begin
                        m_good[i] = 0;
                        err = 1'b1;
                    end
                end
                default: if ((chk && !pass) || (!ev[2] && cb[2] == sat[i])) begin
                    m_st[i] = 1;
                    m_good[i] = 0;
                    err = 1'b1;
                end
            endcase
            m_sticky[i] = err || m_pulse[i] || (m_sticky[i] && !clr);
            m_pulse[i] = err;
            for (int x = 0; x < 3; x++) begin
                if (ev[x]) begin
                    m_per[i][x] = cb[x];
                    m_last[i][x] = tnow;
                    m_nr[i][x]++;
                end
            end
        end
    endfunction

    task automatic cmp(input string nm, input int act, input int exp);
        nvec++;
        if (act != exp) begin
            nbad++;
            $display("FAIL %s: got %0d, expected %0d (edge %0d)",
                     nm, act, exp, tnow);
        end
    endtask

    task automatic cmp_model();
        cmp("locked8", int'(lk8), int'(m_st[0] == 2));
        cmp("pulse8", int'(ep8), int'(m_pulse[0]));
        cmp("sticky8", int'(es8), int'(m_sticky[0]));
        cmp("mper8", int'(mp8), m_per[0][0]);
        cmp("fper8", int'(fp8), m_per[0][2]);
        cmp("locked4", int'(lk4), int'(m_st[1] == 2));
        cmp("pulse4", int'(ep4), int'(m_pulse[1]));
        cmp("sticky4", int'(es4), int'(m_sticky[1]));
        cmp("mper4", int'(mp4), m_per[1][0]);
        cmp("fper4", int'(fp4), m_per[1][2]);
    endtask

    task automatic cmp_zero(input string nm);
        cmp({nm, "_lk8"}, int'(lk8), 0);
        cmp({nm, "_ep8"}, int'(ep8), 0);
        cmp({nm, "_es8"}, int'(es8), 0);
        cmp({nm, "_mp8"}, int'(mp8), 0);
        cmp({nm, "_fp8"}, int'(fp8), 0);
        cmp({nm, "_lk4"}, int'(lk4), 0);
        cmp({nm, "_es4"}, int'(es4), 0);
        cmp({nm, "_fp4"}, int'(fp4), 0);
    endtask

    // Entered and left at a negedge.
    task automatic tick();
        main_in = ((ph % pm) < (pm / 2));
        two_in  = ((ph % p2) < (p2 / 2));
        four_in = freeze4 ? 1'b0 : ((ph % p4) < (p4 / 2));
        ph++;
        @(posedge clk);
        model_step(main_in, two_in, four_in, clr_err);
        #1;
        cmp_model();
        @(negedge clk);
    endtask

    task automatic ticks(input int n);
        for (int k = 0; k < n; k++) tick();
    endtask

    task automatic do_reset();
        #2;
        resetn = 1'b0;
        #1;
        cmp_zero("rst");
        model_reset();
        ph = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        resetn = 1'b1;
    endtask

    typedef struct {
        bit rst;
        int pm, p2, p4, ncyc;
        bit clr;
        int e_mp, e_fp, e_lk, e_es;
    } vec_t;

    vec_t tbl[5];
    int hits, c8, c4;

    initial begin
        tbl[0] = '{0, 2, 4, 8, 80, 0, 2, 8, 1, 0};
        tbl[1] = '{0, 2, 8, 8, 20, 0, 2, 8, 0, 1};
        tbl[2] = '{0, 2, 4, 8, 12, 1, 2, 8, 0, 0};
        tbl[3] = '{0, 2, 4, 8, 60, 0, 2, 8, 1, 0};
        tbl[4] = '{1, 6, 12, 24, 250, 0, 6, 24, 1, 0};

        model_reset();
        repeat (3) @(posedge clk);
        #1;
        cmp_zero("init");
        @(negedge clk);
        resetn = 1'b1;

        for (int v = 0; v < 5; v++) begin
            if (tbl[v].rst) do_reset();
            pm = tbl[v].pm;
            p2 = tbl[v].p2;
            p4 = tbl[v].p4;
            clr_err = tbl[v].clr;
            ticks(tbl[v].ncyc);
            clr_err = 1'b0;
            cmp($sformatf("tbl%0d_mper", v), int'(mp8), tbl[v].e_mp);
            cmp($sformatf("tbl%0d_fper", v), int'(fp8), tbl[v].e_fp);
            cmp($sformatf("tbl%0d_lock", v), int'(lk8), tbl[v].e_lk);
            cmp($sformatf("tbl%0d_stky", v), int'(es8), tbl[v].e_es);
        end

        pm = 2; p2 = 4; p4 = 8;
        ticks(120);
        cmp("pre_stall_lk8", int'(lk8), 1);
        cmp("pre_stall_lk4", int'(lk4), 1);

        freeze4 = 1'b1;
        c8 = 0;
        c4 = 0;
        for (int k = 0; k < 300; k++) begin
            tick();
            c8 += int'(ep8);
            c4 += int'(ep4);
        end
        cmp("stall_pulses8", c8, 1);
        cmp("stall_pulses4", c4, 1);
        cmp("stall_lk8", int'(lk8), 0);
        cmp("stall_lk4", int'(lk4), 0);
        cmp("stall_es4", int'(es4), 1);
        freeze4 = 1'b0;
        ticks(120);
        cmp("relock_lk8", int'(lk8), 1);
        cmp("relock_lk4", int'(lk4), 1);

        cmp("clr_before", int'(es8), 1);
        clr_err = 1'b1;
        tick();
        clr_err = 1'b0;
        cmp("clr_after", int'(es8), 0);

        clr_err = 1'b1;
        p2 = 8;
        hits = 0;
        for (int k = 0; k < 40; k++) begin
            tick();
            if (ep8) begin
                hits++;
                cmp("collide_sticky", int'(es8), 1);
            end
        end
        cmp("collide_hits", int'(hits > 1), 1);
        clr_err = 1'b0;
        p2 = 4;
        ticks(100);

        for (int s = 0; s < 30; s++) begin
            pm = int'($urandom_range(2, 6));
            p2 = ($urandom_range(0, 3) != 0) ? 2 * pm
                                             : int'($urandom_range(2, 14));
            p4 = ($urandom_range(0, 3) != 0) ? 4 * pm
                                             : int'($urandom_range(2, 28));
            for (int k = 0; k < int'($urandom_range(30, 90)); k++) begin
                clr_err = ($urandom_range(0, 7) == 0);
                tick();
            end
        end
        clr_err = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
